// File: rtl/fanout_bcast_tree.sv
// Pipelined broadcast tree: one DATA_W word fanned out to FANOUT**LEVELS masked copies,
// one register layer per tree level, valid/ready with per-stage backpressure.
module fanout_bcast_tree #(
    parameter int DATA_W = 16,
    parameter int FANOUT = 4,
    parameter int LEVELS = 3,
    parameter int CNT_W  = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [DATA_W-1:0]                 in_data_i,
    input  logic [FANOUT**LEVELS-1:0]         in_mask_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [FANOUT**LEVELS*DATA_W-1:0]  out_data_o,
    output logic [CNT_W-1:0]                  out_cnt_o
);

    function automatic int pow_f(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    // Number of copies held in levels 0..n-1 (level 0 is the input word).
    function automatic int geo_f(input int n);
        int s;
        s = 0;
        for (int m = 0; m < n; m++) s = s + pow_f(FANOUT, m);
        return s;
    endfunction

    localparam int NUM_OUT  = pow_f(FANOUT, LEVELS);
    localparam int DQ_W     = (geo_f(LEVELS + 1) - 1) * DATA_W;
    localparam int LAST_OFF = (geo_f(LEVELS) - 1) * DATA_W;
    localparam int CHAIN_W  = geo_f(LEVELS) * DATA_W;
    localparam int MSK_N    = (LEVELS > 1) ? LEVELS - 1 : 1;

    // All stage data registers packed level after level; level k copy i sits at
    // word index geo_f(k)-1+i.
    logic [DQ_W-1:0]          data_q, data_d;
    logic [MSK_N*NUM_OUT-1:0] mask_q, mask_d;
    logic [LEVELS-1:0]        valid_q, valid_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [LEVELS-1:0]        rdy;
    logic [LEVELS-1:0]        valid_src;
    logic [CHAIN_W-1:0]       data_chain;
    logic [LEVELS*NUM_OUT-1:0] mask_chain;
    logic                     in_fire;
    logic                     out_fire;

    // Source views: input word/mask followed by every non-final stage.
    if (LEVELS == 1) begin : g_one
        assign data_chain = in_data_i;
        assign mask_chain = in_mask_i;
    end else begin : g_multi
        assign data_chain = {data_q[LAST_OFF-1:0], in_data_i};
        assign mask_chain = {mask_q, in_mask_i};
    end

    always_comb begin
        logic blk;
        blk = ~out_ready_i;
        rdy = '0;
        for (int k = LEVELS - 1; k >= 0; k--) begin
            blk    = blk & valid_q[k];
            rdy[k] = ~blk;
        end
    end

    assign in_ready_o = rdy[0] & ~flush_i;
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = valid_q[LEVELS-1] & out_ready_i;
    assign valid_src  = LEVELS'({valid_q, in_fire});

    always_comb begin
        logic [DATA_W-1:0] src;
        src     = '0;
        data_d  = data_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        cnt_d   = out_fire ? cnt_q + CNT_W'(1) : cnt_q;
        if (flush_i) begin
            valid_d = '0;
        end else begin
            for (int k = 1; k <= LEVELS; k++) begin
                if (rdy[k-1]) begin
                    valid_d[k-1] = valid_src[k-1];
                    for (int i = 0; i < pow_f(FANOUT, k); i++) begin
                        src = data_chain[(geo_f(k - 1) + i / FANOUT) * DATA_W +: DATA_W];
                        if (k == LEVELS && !mask_chain[(LEVELS - 1) * NUM_OUT + i]) src = '0;
                        data_d[(geo_f(k) - 1 + i) * DATA_W +: DATA_W] = src;
                    end
                    if (k < LEVELS) mask_d[(k - 1) * NUM_OUT +: NUM_OUT] = mask_chain[(k - 1) * NUM_OUT +: NUM_OUT];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            mask_q  <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid_o = valid_q[LEVELS-1];
    assign out_data_o  = data_q[LAST_OFF +: NUM_OUT*DATA_W];
    assign out_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fanout_bcast_tree.sv
// Bench for fanout_bcast_tree: default tree, a 4-bit counter variant and a
// DATA_W=8/FANOUT=2/LEVELS=4 variant, each checked against a scoreboard queue.
module tb_fanout_bcast_tree;

    typedef logic [1023:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t exp64(input logic [15:0] d, input logic [63:0] m);
        vec_t r;
        r = '0;
        for (int j = 0; j < 64; j++) if (m[j]) r[j*16 +: 16] = d;
        return r;
    endfunction

    function automatic vec_t exp16(input logic [7:0] d, input logic [15:0] m);
        vec_t r;
        r = '0;
        for (int j = 0; j < 16; j++) if (m[j]) r[j*8 +: 8] = d;
        return r;
    endfunction

    // default tree
    logic rst = 1'b1, flush0 = 1'b0, iv0 = 1'b0, or0 = 1'b1;
    logic ir0, ov0;
    logic [15:0] id0 = '0;
    logic [63:0] im0 = '1;
    logic [1023:0] od0;
    logic [15:0] cnt0;

    fanout_bcast_tree u_dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush0), .in_valid_i(iv0), .in_ready_o(ir0),
        .in_data_i(id0), .in_mask_i(im0), .out_valid_o(ov0), .out_ready_i(or0),
        .out_data_o(od0), .out_cnt_o(cnt0));

    // narrow-counter tree
    logic rst1 = 1'b1, flush1 = 1'b0, iv1 = 1'b0, or1 = 1'b1;
    logic ir1, ov1;
    logic [15:0] id1 = '0;
    logic [63:0] im1 = '1;
    logic [1023:0] od1;
    logic [3:0] cnt1;

    fanout_bcast_tree #(.CNT_W(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .flush_i(flush1), .in_valid_i(iv1), .in_ready_o(ir1),
        .in_data_i(id1), .in_mask_i(im1), .out_valid_o(ov1), .out_ready_i(or1),
        .out_data_o(od1), .out_cnt_o(cnt1));

    // swept-parameter tree
    logic flush2 = 1'b0, iv2 = 1'b0, or2 = 1'b1;
    logic ir2, ov2;
    logic [7:0] id2 = '0;
    logic [15:0] im2 = '1;
    logic [127:0] od2;
    logic [15:0] cnt2;

    fanout_bcast_tree #(.DATA_W(8), .FANOUT(2), .LEVELS(4)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush2), .in_valid_i(iv2), .in_ready_o(ir2),
        .in_data_i(id2), .in_mask_i(im2), .out_valid_o(ov2), .out_ready_i(or2),
        .out_data_o(od2), .out_cnt_o(cnt2));

    vec_t q0[$];
    int   c0[$];
    bit   lat0 = 1'b0;
    vec_t q2[$];
    int   c2[$];
    bit   lat2 = 1'b0;
    int   n_push2 = 0;

    always @(negedge clk) begin : mon0
        vec_t e;
        int c;
        if (rst) begin
            q0.delete();
            c0.delete();
        end else begin
            if (ov0 && or0) begin
                if (q0.size() == 0) chk("unexp0", vec_t'(ov0), '0);
                else begin
                    e = q0.pop_front();
                    c = c0.pop_front();
                    chk("data0", od0, e);
                    if (lat0) chk("lat0", vec_t'(cyc - c), vec_t'(3));
                end
            end
            if (flush0) begin
                q0.delete();
                c0.delete();
            end
            if (iv0 && ir0) begin
                q0.push_back(exp64(id0, im0));
                c0.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin : mon2
        vec_t e;
        int c;
        bit stall_prev;
        vec_t od_prev;
        if (rst) begin
            q2.delete();
            c2.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("swp_hold_v", vec_t'(ov2), vec_t'(1));
                chk("swp_hold_d", vec_t'(od2), od_prev);
            end
            stall_prev = ov2 && !or2;
            od_prev    = vec_t'(od2);
            if (ov2 && or2) begin
                if (q2.size() == 0) chk("unexp2", vec_t'(ov2), '0);
                else begin
                    e = q2.pop_front();
                    c = c2.pop_front();
                    chk("data2", vec_t'(od2), e);
                    if (lat2) chk("lat2", vec_t'(cyc - c), vec_t'(4));
                end
            end
            if (iv2 && ir2) begin
                q2.push_back(exp16(id2, im2));
                c2.push_back(cyc);
                n_push2++;
            end
        end
    end

    task automatic send0(input logic [15:0] d, input logic [63:0] m);
        bit ok;
        ok  = 1'b0;
        iv0 = 1'b1; id0 = d; im0 = m;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = ir0;
        end
        if (!ok) chk("send0_tmo", vec_t'(ir0), vec_t'(1));
        @(posedge clk); #1;
        iv0 = 1'b0;
    endtask

    task automatic send1(input logic [15:0] d);
        bit ok;
        ok  = 1'b0;
        iv1 = 1'b1; id1 = d;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = ir1;
        end
        if (!ok) chk("send1_tmo", vec_t'(ir1), vec_t'(1));
        @(posedge clk); #1;
        iv1 = 1'b0;
    endtask

    task automatic send2(input logic [7:0] d, input logic [15:0] m);
        bit ok;
        ok  = 1'b0;
        iv2 = 1'b1; id2 = d; im2 = m;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = ir2;
        end
        if (!ok) chk("send2_tmo", vec_t'(ir2), vec_t'(1));
        @(posedge clk); #1;
        iv2 = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        vec_t snap;
        // reset, two cycles
        @(posedge clk);
        @(negedge clk);
        chk("rst_od0", od0, '0);
        chk("rst_ov0", vec_t'(ov0), '0);
        chk("rst_cnt0", vec_t'(cnt0), '0);
        @(posedge clk); #1;
        rst = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", vec_t'(ir0), vec_t'(1));
        @(posedge clk); #1;

        // back-to-back stream, latency 3
        lat0 = 1'b1;
        send0(16'h1234, '1);
        send0(16'h5678, '1);
        send0(16'hABCD, '1);
        repeat (6) @(posedge clk); #1;
        lat0 = 1'b0;
        chk("stream_cnt", vec_t'(cnt0), vec_t'(3));

        // mask sampled at input handshake
        send0(16'hBEEF, 64'h0000_0000_0000_00F0);
        im0 = '1;
        for (int k = 0; k < 10 && !ov0; k++) @(negedge clk);
        chk("mask_ov", vec_t'(ov0), vec_t'(1));
        chk("mask_c4", vec_t'(od0[64 +: 16]), vec_t'(16'hBEEF));
        chk("mask_c7", vec_t'(od0[112 +: 16]), vec_t'(16'hBEEF));
        chk("mask_c3", vec_t'(od0[48 +: 16]), '0);
        chk("mask_c8", vec_t'(od0[128 +: 16]), '0);
        @(posedge clk); #1;
        repeat (4) @(posedge clk); #1;

        // backpressure
        or0 = 1'b0;
        send0(16'h0001, '1);
        send0(16'h0002, '1);
        send0(16'h0003, '1);
        iv0 = 1'b1; id0 = 16'h0004;
        @(negedge clk);
        chk("bp_irdy", vec_t'(ir0), '0);
        chk("bp_ov", vec_t'(ov0), vec_t'(1));
        chk("bp_word1", od0, exp64(16'h0001, '1));
        snap = od0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", od0, snap);
            chk("bp_irdy_hold", vec_t'(ir0), '0);
        end
        @(posedge clk); #1;
        or0 = 1'b1;
        send0(16'h0004, '1);
        send0(16'h0005, '1);
        repeat (8) @(posedge clk); #1;
        chk("bp_cnt", vec_t'(cnt0), vec_t'(9));

        // flush with word 1 at the output being accepted
        send0(16'h0A06, '1);
        send0(16'h0A07, '1);
        send0(16'h0A08, '1);
        flush0 = 1'b1;
        @(negedge clk);
        chk("fl_irdy", vec_t'(ir0), '0);
        chk("fl_ov", vec_t'(ov0), vec_t'(1));
        @(posedge clk); #1;
        flush0 = 1'b0;
        @(negedge clk);
        chk("fl_irdy_after", vec_t'(ir0), vec_t'(1));
        chk("fl_ov_after", vec_t'(ov0), '0);
        chk("fl_cnt", vec_t'(cnt0), vec_t'(10));
        repeat (6) @(posedge clk); #1;
        chk("fl_cnt_late", vec_t'(cnt0), vec_t'(10));
        chk("sb0_left", vec_t'(q0.size()), '0);

        // counter wrap on the 4-bit variant
        for (int k = 0; k < 16; k++) send1(16'(k));
        repeat (6) @(posedge clk); #1;
        chk("wrap16", vec_t'(cnt1), '0);
        send1(16'h0011);
        repeat (6) @(posedge clk); #1;
        chk("wrap17", vec_t'(cnt1), vec_t'(1));
        or1 = 1'b0;
        send1(16'h00AA);
        send1(16'h00BB);
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        @(negedge clk);
        chk("mrst_ov", vec_t'(ov1), '0);
        chk("mrst_cnt", vec_t'(cnt1), '0);
        chk("mrst_od", od1, '0);
        chk("mrst_irdy", vec_t'(ir1), vec_t'(1));
        @(posedge clk); #1;

        // swept tree: latency 4, then random traffic
        lat2 = 1'b1;
        send2(8'h11, '1);
        send2(8'h22, 16'hA5A5);
        send2(8'h33, 16'h0001);
        repeat (8) @(posedge clk); #1;
        lat2 = 1'b0;
        repeat (400) begin
            iv2 = 1'($urandom_range(0, 1));
            id2 = 8'($urandom);
            im2 = 16'($urandom);
            or2 = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        iv2 = 1'b0;
        or2 = 1'b1;
        repeat (10) @(posedge clk); #1;
        chk("swp_left", vec_t'(q2.size()), '0);
        chk("swp_cnt", vec_t'(cnt2), vec_t'(n_push2));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fanout_bcast_tree.md
Name: fanout_bcast_tree

Overview:
- Parametrised, pipelined broadcast tree. Takes one DATA_W word and replicates it into FANOUT**LEVELS copies, with one register level per tree layer so no single driver sees a large fanout.
- Successor to the fixed 16->1024 fanout trees. Adds the following:
  - generic width, fanout and depth;
  - a valid/ready handshake on both sides, with per-stage backpressure;
  - a per-copy zeroing mask;
  - a synchronous flush;
  - a delivered-transfer counter.
- Sits between a scalar producer (weight/activation fetch) and a wide PE array.

Parameters:
DATA_W, 16, width of one data word
FANOUT, 4, copies produced per register at each level
LEVELS, 3, number of register levels; NUM_OUT = FANOUT**LEVELS (default 64 copies, 1024-bit output)
CNT_W, 16, width of the delivered-transfer counter

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous pipeline clear; data and counter are not cleared
in_valid  in  1  input word valid
in_ready  out  1  tree can accept in_data this cycle
in_data  in  DATA_W  word to broadcast
in_mask  in  NUM_OUT  per-copy enable; bit j=0 forces output copy j to zero
out_valid  out  1  broadcast word valid
out_ready  in  1  consumer accepts out_data this cycle
out_data  out  NUM_OUT*DATA_W  copy j on bits [j*DATA_W +: DATA_W]
out_cnt  out  CNT_W  number of output handshakes completed, modulo 2**CNT_W

Behaviour:
- Reset is one clock, synchronous and active-high (clk, rst). On rst:
  - all stage valids, out_valid and out_cnt go to 0;
  - all data and mask registers go to 0, so out_data=0;
  - in_ready is 1 in the first cycle after rst deasserts, or 0 if flush is high.
- Structure:
  - Stage k (1..LEVELS) holds FANOUT**k copies of the data, a copy of the mask, and one valid bit v[k].
  - Copy i of stage k loads from copy i/FANOUT of stage k-1; stage 0 is in_data.
  - Mask copies follow the same pattern, so the mask is carried alongside its word.
  - Final stage: copy j loads the data when the carried mask bit j=1, else loads 0.
- Handshake:
  - rdy[LEVELS] = ~v[LEVELS] | out_ready.
  - rdy[k] = ~v[k] | rdy[k+1].
  - in_ready = rdy[1] & ~flush.
  - Stage k loads when rdy[k] is 1; then v[k] <= v[k-1], and v[0] = in_valid & in_ready.
  - A stage that is not ready holds its data, mask and valid.
  - The ready path is combinational across all LEVELS stages. There is no skid buffer.
  - out_valid = v[LEVELS]; out_data is the stage-LEVELS data registers.
- Latency and throughput:
  - With out_ready held at 1, a word accepted in cycle t appears with out_valid=1 in cycle t+LEVELS.
  - Throughput is 1 word/cycle.
  - Bubbles compress: a stall only back-propagates up to the first empty stage.
- Data stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change.
- Mask: sampled together with in_data at the input handshake. A later change to in_mask has no effect on words already in flight.
- Counter: out_cnt increments by 1 on each cycle where out_valid & out_ready; it wraps from 2**CNT_W-1 to 0.
- flush:
  - Effect on the next edge: all v[k] <= 0.
  - in_ready=0 during the flush cycle, so no word enters.
  - Data and mask registers hold their values; out_cnt is not cleared.
- Flush with a simultaneous output handshake: the transfer counts (out_cnt increments) and the word is considered delivered.
- rst mid-operation: rst dominates flush and all handshakes. In-flight words are discarded and out_cnt returns to 0.
- in_valid=0 with in_ready=1: stage 1 loads v=0. Data registers may load don't-care values; verification checks data only when out_valid=1.
- Full pipeline: LEVELS words in flight. in_ready=0 only when all stages are valid and out_ready=0.

Test Plan:
- Reset then streaming, defaults: rst 2 cycles, then in_data=0x1234, 0x5678, 0xABCD on back-to-back cycles, in_mask all ones, out_ready=1 -> outputs on cycles t+3, t+4, t+5, each with all 64 copies equal; out_cnt=3; out_data=0 during reset.
- Mask: in_data=0xBEEF with in_mask=64'h0000_0000_0000_00F0; in_mask is changed to all ones while the word is in flight -> only copies 4..7 = 0xBEEF, all other copies 0.
- Backpressure:
  - Stream 5 words with out_ready=0 -> in_ready drops after 3 accepted words.
  - out_data holds word 1 steady.
  - Then out_ready=1 -> words 1..5 are delivered in order, none lost or duplicated; out_cnt=5.
- Flush: 3 words in flight, flush=1 for 1 cycle with out_ready=1 and word 1 at the output -> word 1 counted (out_cnt+1); words 2 and 3 never appear; in_ready=0 during flush, 1 the cycle after.
- Counter wrap and mid-run reset, with CNT_W=4: 17 handshakes -> out_cnt=1. Then rst asserted with 2 words in flight -> out_valid=0 and out_cnt=0 the next cycle.
- Parameter sweep: DATA_W=8, FANOUT=2, LEVELS=4 (16 copies, 128-bit output) -> latency 4 cycles; random valid/ready traffic matches a scoreboard model.
